// File: rtl/window_feeder.sv
// Feeds FWFT FIFO pixels, one per shift strobe, into the convolver's 3-tap shift register.
// Define WINDOW_FEEDER_PAD_EN to insert one zero pixel at each row edge.
module window_feeder #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_cols,
    input  logic [CNT_W-1:0]  cfg_rows,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    input  logic              stall,
    output logic [DATA_W-1:0] sr_data,
    output logic              sr_shift,
    output logic              win_valid,
    output logic              row_last,
    output logic              frame_done,
    output logic              busy
);

    // In-row shift count needs room for cfg_cols + 2 when padding is enabled.
    localparam int unsigned KW = CNT_W + 2;

`ifdef WINDOW_FEEDER_PAD_EN
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPadL   = 3'd1,
        StStream = 3'd2,
        StPadR   = 3'd3,
        StDone   = 3'd4
    } state_e;
    localparam state_e StRowStart = StPadL;
`else
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStream = 3'd2,
        StDone   = 3'd4
    } state_e;
    localparam state_e StRowStart = StStream;
`endif

    state_e state_q, state_d;

    logic [CNT_W-1:0]  cols_q, rows_q;
    logic [CNT_W-1:0]  col_cnt_q, row_cnt_q;
    logic [CNT_W-1:0]  col_nxt, row_nxt;
    logic [KW-1:0]     k_q, k_nxt;
    logic [DATA_W-1:0] sr_data_q;
    logic              sr_shift_q, win_valid_q, row_last_q, frame_done_q, busy_q;

    logic              issue, pop, row_end, cfg_load, col_last, row_is_last;
    logic [DATA_W-1:0] issue_data;

    assign col_nxt     = col_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign row_nxt     = row_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign k_nxt       = k_q + {{(KW-1){1'b0}}, 1'b1};
    assign col_last    = (col_nxt == cols_q);
    assign row_is_last = (row_nxt == rows_q);

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_data = '0;
        pop        = 1'b0;
        row_end    = 1'b0;
        cfg_load   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_cols != '0 && cfg_rows != '0) begin
                        cfg_load = 1'b1;
                        state_d  = StRowStart;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
`ifdef WINDOW_FEEDER_PAD_EN
            StPadL: begin
                if (!stall) begin
                    issue   = 1'b1;
                    state_d = StStream;
                end
            end
            StPadR: begin
                if (!stall) begin
                    issue   = 1'b1;
                    row_end = 1'b1;
                end
            end
`endif
            StStream: begin
                if (!fifo_empty && !stall) begin
                    pop        = 1'b1;
                    issue      = 1'b1;
                    issue_data = fifo_dout;
                    if (col_last) begin
`ifdef WINDOW_FEEDER_PAD_EN
                        state_d = StPadR;
`else
                        row_end = 1'b1;
`endif
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (row_end) begin
            state_d = row_is_last ? StDone : StRowStart;
        end
    end

    // Pop strobe is combinational off the FWFT head; reset masks it immediately.
    assign fifo_rd_en = pop && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cols_q       <= '0;
            rows_q       <= '0;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            k_q          <= '0;
            sr_data_q    <= '0;
            sr_shift_q   <= 1'b0;
            win_valid_q  <= 1'b0;
            row_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_shift_q   <= issue;
            win_valid_q  <= issue && (k_nxt >= KW'(3));
            row_last_q   <= row_end;
            frame_done_q <= (state_q == StDone);

            if (issue) begin
                sr_data_q <= issue_data;
                k_q       <= row_end ? '0 : k_nxt;
            end
            if (pop) begin
                col_cnt_q <= col_last ? '0 : col_nxt;
            end
            if (row_end) begin
                row_cnt_q <= row_nxt;
            end

            if (cfg_load) begin
                cols_q    <= cfg_cols;
                rows_q    <= cfg_rows;
                col_cnt_q <= '0;
                row_cnt_q <= '0;
                k_q       <= '0;
                busy_q    <= 1'b1;
            end else if (state_q == StDone) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign sr_data    = sr_data_q;
    assign sr_shift   = sr_shift_q;
    assign win_valid  = win_valid_q;
    assign row_last   = row_last_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_window_feeder.sv
// Directed self-checking bench for window_feeder with a queue-based FWFT FIFO model.
module tb_window_feeder;

    localparam int DW = 16;
    localparam int CW = 10;
`ifdef WINDOW_FEEDER_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    logic          clk, rst, start, fifo_empty, fifo_rd_en, stall;
    logic [CW-1:0] cfg_cols, cfg_rows;
    logic [DW-1:0] fifo_dout, sr_data;
    logic          sr_shift, win_valid, row_last, frame_done, busy;

    window_feeder #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_cols   (cfg_cols),
        .cfg_rows   (cfg_rows),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .stall      (stall),
        .sr_data    (sr_data),
        .sr_shift   (sr_shift),
        .win_valid  (win_valid),
        .row_last   (row_last),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] fifo_q[$];
    bit            force_empty;
    int            cyc = 0;
    logic          stall_hist[0:4095];
    logic [DW-1:0] sh_data[$];
    bit            sh_win[$];
    bit            sh_last[$];
    int            sh_cyc[$];
    int            done_cnt, done_cyc, pops, viol;

    always @(posedge clk) begin
        stall_hist[cyc % 4096] = stall;
        if (fifo_rd_en) begin
            if (fifo_empty || stall) viol++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pops++;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (sr_shift) begin
            sh_data.push_back(sr_data);
            sh_win.push_back(win_valid);
            sh_last.push_back(row_last);
            sh_cyc.push_back(cyc);
            if (stall_hist[(cyc - 1) % 4096] === 1'b1) viol++;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        fifo_empty = force_empty || (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_logs();
        sh_data.delete();
        sh_win.delete();
        sh_last.delete();
        sh_cyc.delete();
        done_cnt = 0;
        pops     = 0;
        viol     = 0;
    endtask

    task automatic load_fifo(input int first, input int n);
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'(first + i));
    endtask

    task automatic do_start(input int c, input int r);
        cfg_cols = CW'(c);
        cfg_rows = CW'(r);
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, ".done_seen"}, 32'(ok), 32'd1);
    endtask

    // Expected stream per row: [0] pixels... [0]; window once k>=3, row_last at k==len.
    task automatic check_frame(input string tag, input int cols, input int rows,
                               input int first, input int stalls);
        int            idx = 0;
        int            n   = 0;
        int            len = cols + (PadEn ? 2 : 0);
        logic [DW-1:0] ev;
        check({tag, ".nshift"}, 32'(sh_data.size()), 32'(rows * len));
        for (int r = 0; r < rows; r++) begin
            for (int k = 1; k <= len; k++) begin
                if (PadEn && (k == 1 || k == len)) begin
                    ev = '0;
                end else begin
                    ev = DW'(first + idx);
                    idx++;
                end
                if (n < sh_data.size()) begin
                    check($sformatf("%s.data%0d", tag, n), 32'(sh_data[n]), 32'(ev));
                    check($sformatf("%s.win%0d", tag, n), 32'(sh_win[n]), 32'(k >= 3));
                    check($sformatf("%s.last%0d", tag, n), 32'(sh_last[n]), 32'(k == len));
                end
                n++;
            end
        end
        if (sh_data.size() == n && n > 0) begin
            check({tag, ".span"}, 32'(sh_cyc[n-1] - sh_cyc[0]), 32'(n - 1 + stalls));
            check({tag, ".done_cyc"}, 32'(done_cyc), 32'(sh_cyc[n-1] + 1));
        end
        check({tag, ".pops"}, 32'(pops), 32'(cols * rows));
        check({tag, ".viol"}, 32'(viol), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".sr_data"}, 32'(sr_data), 32'd0);
        check({tag, ".sr_shift"}, 32'(sr_shift), 32'd0);
        check({tag, ".win_valid"}, 32'(win_valid), 32'd0);
        check({tag, ".row_last"}, 32'(row_last), 32'd0);
        check({tag, ".frame_done"}, 32'(frame_done), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".fifo_rd_en"}, 32'(fifo_rd_en), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        stall       = 1'b0;
        cfg_cols    = '0;
        cfg_rows    = '0;
        force_empty = 1'b0;
        fifo_empty  = 1'b1;
        fifo_dout   = '0;
        for (int i = 0; i < 4096; i++) stall_hist[i] = 1'b0;
        clear_logs();
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Basic frame: 4x2 of pixels 1..8, no stall.
        clear_logs();
        load_fifo(1, 8);
        tick();
        do_start(4, 2);
        check("basic.busy_on", 32'(busy), 32'd1);
        wait_done("basic", 60);
        check("basic.busy_off", 32'(busy), 32'd0);
        check_frame("basic", 4, 2, 1, 0);
        tick();
        check("basic.done_pulse", 32'(frame_done), 32'd0);

`ifdef WINDOW_FEEDER_PAD_EN
        clear_logs();
        load_fifo(5, 3);
        tick();
        do_start(3, 1);
        wait_done("pad", 40);
        check_frame("pad", 3, 1, 5, 0);
        tick();
`endif

        // Stall for three issuing cycles after the first pixel.
        clear_logs();
        load_fifo(10, 6);
        tick();
        do_start(6, 1);
`ifdef WINDOW_FEEDER_PAD_EN
        tick();
`endif
        tick();
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        wait_done("stall", 60);
        check_frame("stall", 6, 1, 10, 3);
        tick();

        // FIFO underrun: empty flag toggles every cycle.
        clear_logs();
        load_fifo(20, 6);
        tick();
        do_start(6, 1);
        for (int i = 0; i < 80 && done_cnt == 0; i++) begin
            force_empty = ~force_empty;
            tick();
        end
        force_empty = 1'b0;
        check("under.done_seen", 32'(done_cnt), 32'd1);
        check("under.nshift", 32'(sh_data.size()), 32'(6 + (PadEn ? 2 : 0)));
        check("under.pops", 32'(pops), 32'd6);
        check("under.viol", 32'(viol), 32'd0);
        tick();

        // Zero config: straight to DONE with no pops or shifts.
        clear_logs();
        load_fifo(99, 1);
        tick();
        do_start(0, 3);
        check("zero.done_early", 32'(frame_done), 32'd0);
        tick();
        check("zero.done", 32'(frame_done), 32'd1);
        check("zero.busy", 32'(busy), 32'd0);
        tick();
        check("zero.done_pulse", 32'(frame_done), 32'd0);
        repeat (3) tick();
        check("zero.nshift", 32'(sh_data.size()), 32'd0);
        check("zero.pops", 32'(pops), 32'd0);

        // Second start while busy must be ignored.
        clear_logs();
        load_fifo(1, 6);
        tick();
        do_start(3, 1);
        do_start(5, 1);
        wait_done("restart", 40);
        repeat (4) tick();
        check_frame("restart", 3, 1, 1, 0);
        check("restart.ndone", 32'(done_cnt), 32'd1);
        check("restart.left", 32'(fifo_q.size()), 32'd3);

        // Reset after the third shift aborts the frame.
        clear_logs();
        load_fifo(1, 8);
        tick();
        do_start(8, 1);
        for (int i = 0; i < 30 && sh_data.size() < 3; i++) tick();
        check("abort.three", 32'(sh_data.size()), 32'd3);
        rst = 1'b1;
        tick();
        check_outputs_zero("abort");
        rst = 1'b0;
        repeat (6) tick();
        check("abort.no_done", 32'(done_cnt), 32'd0);
        check("abort.no_shift", 32'(sh_data.size()), 32'd3);

        clear_logs();
        load_fifo(1, 8);
        tick();
        do_start(4, 2);
        wait_done("after_abort", 60);
        check_frame("after_abort", 4, 2, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
